// File: rtl/gram_sdram_scheduler.sv
// ---------------------------------------------------------------------------
// gram_sdram_scheduler
//
// Single-owner burst scheduler for the SDRAM frame-buffer core. It chooses
// between draining the camera input FIFO (write bursts) and filling the VGA
// output FIFO (read bursts). At most one burst is outstanding. It generates
// burst addresses and runs the per-frame bank ping-pong between the writer
// and the reader.
//
// Ports
//   clk            100 MHz SDRAM controller clock
//   rst_n          synchronous active-low reset
//   init_done      SDRAM initialisation complete
//   wr_level       input FIFO read-side used words
//   rd_level       output FIFO write-side used words
//   core_wr_busy   sdram_core write burst in progress
//   core_rd_busy   sdram_core read burst in progress
//   wr_request     one-cycle write burst request
//   rd_request     one-cycle read burst request
//   wr_addr        {wr_bank, wr_rowcol} of the current/next write burst
//   rd_addr        {rd_bank, rd_rowcol} of the current/next read burst
//   frame_wr_done  one-cycle pulse after the last write burst of a frame
//   frame_rd_done  one-cycle pulse after the last read burst of a frame
//   timeout_err    sticky: the core never raised busy after a request
// ---------------------------------------------------------------------------
module gram_sdram_scheduler #(
    parameter int BANK_WIDTH    = 2,
    parameter int ROWCOL_WIDTH  = 22,
    parameter int LEVEL_WIDTH   = 9,
    parameter int FIFO_DEPTH    = 512,
    parameter int BURST_LEN     = 256,
    parameter int BLK_PER_FRAME = 1200,
    parameter int RD_URGENT     = 64,
    parameter int BUSY_TIMEOUT  = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               init_done,
    input  logic [LEVEL_WIDTH-1:0]             wr_level,
    input  logic [LEVEL_WIDTH-1:0]             rd_level,
    input  logic                               core_wr_busy,
    input  logic                               core_rd_busy,
    output logic                               wr_request,
    output logic                               rd_request,
    output logic [BANK_WIDTH+ROWCOL_WIDTH-1:0] wr_addr,
    output logic [BANK_WIDTH+ROWCOL_WIDTH-1:0] rd_addr,
    output logic                               frame_wr_done,
    output logic                               frame_rd_done,
    output logic                               timeout_err
);

    // Block counters are sized for the largest supported frame (8192 bursts).
    localparam int BLK_WIDTH   = 13;
    localparam int CNT_WIDTH   = $clog2(BUSY_TIMEOUT + 1);
    localparam int RD_MAX_I    = FIFO_DEPTH - BURST_LEN;
    localparam int BLK_LAST_I  = BLK_PER_FRAME - 1;
    localparam int CNT_LAST_I  = BUSY_TIMEOUT - 1;

    // Level thresholds are one bit wider than the levels so that a threshold
    // equal to FIFO_DEPTH cannot wrap.
    localparam logic [LEVEL_WIDTH:0]    WR_MIN      = BURST_LEN[LEVEL_WIDTH:0];
    localparam logic [LEVEL_WIDTH:0]    RD_MAX      = RD_MAX_I[LEVEL_WIDTH:0];
    localparam logic [LEVEL_WIDTH:0]    URGENT_LVL  = RD_URGENT[LEVEL_WIDTH:0];
    localparam logic [BLK_WIDTH-1:0]    BLK_LAST    = BLK_LAST_I[BLK_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0]    CNT_LAST    = CNT_LAST_I[CNT_WIDTH-1:0];
    localparam logic [ROWCOL_WIDTH-1:0] ROWCOL_STEP = BURST_LEN[ROWCOL_WIDTH-1:0];

    localparam logic [3:0] S_IDLE         = 4'd0;
    localparam logic [3:0] S_ISSUE_WR     = 4'd1;
    localparam logic [3:0] S_WAIT_RISE_WR = 4'd2;
    localparam logic [3:0] S_WAIT_FALL_WR = 4'd3;
    localparam logic [3:0] S_DONE_WR      = 4'd4;
    localparam logic [3:0] S_ISSUE_RD     = 4'd5;
    localparam logic [3:0] S_WAIT_RISE_RD = 4'd6;
    localparam logic [3:0] S_WAIT_FALL_RD = 4'd7;
    localparam logic [3:0] S_DONE_RD      = 4'd8;

    logic [3:0]              state;
    logic                    last_grant_rd;
    logic [CNT_WIDTH-1:0]    wait_cnt;
    logic                    wr_busy_q;
    logic                    rd_busy_q;
    logic [BANK_WIDTH-1:0]   wr_bank;
    logic [BANK_WIDTH-1:0]   rd_bank;
    logic [ROWCOL_WIDTH-1:0] wr_rowcol;
    logic [ROWCOL_WIDTH-1:0] rd_rowcol;
    logic [BLK_WIDTH-1:0]    wr_blk;
    logic [BLK_WIDTH-1:0]    rd_blk;

    logic [LEVEL_WIDTH:0]    wr_lvl;
    logic [LEVEL_WIDTH:0]    rd_lvl;
    logic                    wr_ok;
    logic                    rd_ok;
    logic                    grant_wr;
    logic                    grant_rd;

    assign wr_lvl  = {1'b0, wr_level};
    assign rd_lvl  = {1'b0, rd_level};
    assign wr_addr = {wr_bank, wr_rowcol};
    assign rd_addr = {rd_bank, rd_rowcol};

    // Arbitration. An almost-empty output FIFO starves the display, so an
    // urgent read wins outright; otherwise contention is round-robin.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        wr_ok    = init_done && (wr_lvl >= WR_MIN) && !core_wr_busy;
        rd_ok    = init_done && (rd_lvl <= RD_MAX) && !core_rd_busy;
        if (rd_ok && (rd_lvl < URGENT_LVL)) begin
            grant_rd = 1'b1;
        end else if (wr_ok && rd_ok) begin
            grant_wr = last_grant_rd;
            grant_rd = !last_grant_rd;
        end else if (wr_ok) begin
            grant_wr = 1'b1;
        end else if (rd_ok) begin
            grant_rd = 1'b1;
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            last_grant_rd <= 1'b1;
            wait_cnt      <= '0;
            wr_busy_q     <= 1'b0;
            rd_busy_q     <= 1'b0;
            wr_bank       <= '0;
            rd_bank       <= '1;
            wr_rowcol     <= '0;
            rd_rowcol     <= '0;
            wr_blk        <= '0;
            rd_blk        <= '0;
            wr_request    <= 1'b0;
            rd_request    <= 1'b0;
            frame_wr_done <= 1'b0;
            frame_rd_done <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            wr_request    <= 1'b0;
            rd_request    <= 1'b0;
            frame_wr_done <= 1'b0;
            frame_rd_done <= 1'b0;
            wr_busy_q     <= core_wr_busy;
            rd_busy_q     <= core_rd_busy;

            case (state)
                S_IDLE: begin
                    // The request register rises together with ISSUE so it is
                    // high for exactly the ISSUE cycle.
                    if (grant_wr) begin
                        wr_request <= 1'b1;
                        state      <= S_ISSUE_WR;
                    end else if (grant_rd) begin
                        rd_request <= 1'b1;
                        state      <= S_ISSUE_RD;
                    end
                end

                S_ISSUE_WR: begin
                    last_grant_rd <= 1'b0;
                    wait_cnt      <= '0;
                    state         <= S_WAIT_RISE_WR;
                end

                S_WAIT_RISE_WR: begin
                    if (core_wr_busy) begin
                        state <= S_WAIT_FALL_WR;
                    end else if (wait_cnt == CNT_LAST) begin
                        // The core ignored the request: give up on this burst
                        // and leave the address where it is so it is retried.
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_WAIT_FALL_WR: begin
                    if (wr_busy_q && !core_wr_busy) begin
                        state <= S_DONE_WR;
                    end
                end

                S_DONE_WR: begin
                    if (wr_blk == BLK_LAST) begin
                        wr_blk        <= '0;
                        wr_rowcol     <= '0;
                        wr_bank       <= ~wr_bank;
                        frame_wr_done <= 1'b1;
                    end else begin
                        wr_blk    <= wr_blk + 1'b1;
                        wr_rowcol <= wr_rowcol + ROWCOL_STEP;
                    end
                    state <= S_IDLE;
                end

                S_ISSUE_RD: begin
                    last_grant_rd <= 1'b1;
                    wait_cnt      <= '0;
                    state         <= S_WAIT_RISE_RD;
                end

                S_WAIT_RISE_RD: begin
                    if (core_rd_busy) begin
                        state <= S_WAIT_FALL_RD;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_WAIT_FALL_RD: begin
                    if (rd_busy_q && !core_rd_busy) begin
                        state <= S_DONE_RD;
                    end
                end

                S_DONE_RD: begin
                    if (rd_blk == BLK_LAST) begin
                        rd_blk        <= '0;
                        rd_rowcol     <= '0;
                        frame_rd_done <= 1'b1;
                        // Follow the writer only once it has moved on to the
                        // other bank; otherwise replay the finished frame.
                        if (rd_bank == wr_bank) begin
                            rd_bank <= ~rd_bank;
                        end
                    end else begin
                        rd_blk    <= rd_blk + 1'b1;
                        rd_rowcol <= rd_rowcol + ROWCOL_STEP;
                    end
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gram_sdram_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gram_sdram_scheduler
//
// Directed bench for gram_sdram_scheduler with a four-burst frame. A busy
// responder plays sdram_core; a burst-level reference model predicts which
// request is granted, the address each burst must carry, and when a frame
// pulse is due. Hand-computed literals pin the model at key points.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gram_sdram_scheduler;

    localparam int BW          = 2;
    localparam int RW          = 22;
    localparam int AW          = BW + RW;
    localparam int LW          = 9;
    localparam int DEPTH       = 512;
    localparam int BURST       = 256;
    localparam int BLK         = 4;
    localparam int URGENT      = 64;
    localparam int TMO         = 64;
    localparam int BUSY_CYCLES = 10;

    localparam int WR_K = 0;
    localparam int RD_K = 1;
    localparam int NO_K = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_done;
    logic [LW-1:0] wr_level;
    logic [LW-1:0] rd_level;
    logic          core_wr_busy;
    logic          core_rd_busy;
    logic          wr_request;
    logic          rd_request;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          frame_wr_done;
    logic          frame_rd_done;
    logic          timeout_err;

    gram_sdram_scheduler #(
        .BANK_WIDTH    (BW),
        .ROWCOL_WIDTH  (RW),
        .LEVEL_WIDTH   (LW),
        .FIFO_DEPTH    (DEPTH),
        .BURST_LEN     (BURST),
        .BLK_PER_FRAME (BLK),
        .RD_URGENT     (URGENT),
        .BUSY_TIMEOUT  (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_done     (init_done),
        .wr_level      (wr_level),
        .rd_level      (rd_level),
        .core_wr_busy  (core_wr_busy),
        .core_rd_busy  (core_rd_busy),
        .wr_request    (wr_request),
        .rd_request    (rd_request),
        .wr_addr       (wr_addr),
        .rd_addr       (rd_addr),
        .frame_wr_done (frame_wr_done),
        .frame_rd_done (frame_rd_done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // ---------------- busy responder (sdram_core stand-in) ----------------
    bit no_rise_next    = 1'b0;  // set by the stimulus: ignore the next request
    bit inflight_noresp = 1'b0;  // the burst in flight will never raise busy

    initial begin
        core_wr_busy = 1'b0;
        core_rd_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wr_request || rd_request) begin
                inflight_noresp = no_rise_next;
                if (!inflight_noresp) begin
                    if (wr_request) core_wr_busy = 1'b1;
                    else            core_rd_busy = 1'b1;
                    repeat (BUSY_CYCLES) @(posedge clk);
                    #1;
                    core_wr_busy = 1'b0;
                    core_rd_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- burst-level reference model ----------------
    int         m_last     = RD_K;
    int         m_wr_done  = 0;     // completed write bursts since reset
    int         m_rd_done  = 0;     // completed read bursts since reset
    logic [1:0] m_rd_bank  = 2'b11;
    bit         m_wr_pend  = 1'b0;  // frame_wr_done owed
    bit         m_rd_pend  = 1'b0;  // frame_rd_done owed
    bit         prev_req   = 1'b0;
    int         wr_cnt     = 0;
    int         rd_cnt     = 0;
    int         wr_frames  = 0;
    int         rd_frames  = 0;
    int         grant_log[$];

    function automatic int model_grant();
        bit w;
        bit r;
        w = init_done && (int'(wr_level) >= BURST);
        r = init_done && (int'(rd_level) <= DEPTH - BURST);
        if (r && int'(rd_level) < URGENT) return RD_K;
        if (w && r) return (m_last == RD_K) ? WR_K : RD_K;
        if (w) return WR_K;
        if (r) return RD_K;
        return NO_K;
    endfunction

    // The writer changes bank once per completed frame.
    function automatic logic [1:0] cur_wr_bank();
        return (((m_wr_done / BLK) % 2) == 1) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [AW-1:0] exp_wr_addr();
        return {cur_wr_bank(), 22'((m_wr_done % BLK) * BURST)};
    endfunction

    function automatic logic [AW-1:0] exp_rd_addr();
        return {m_rd_bank, 22'((m_rd_done % BLK) * BURST)};
    endfunction

    always @(negedge clk) begin : compare
        int g;
        if (!rst_n) begin
            m_last    = RD_K;
            m_wr_done = 0;
            m_rd_done = 0;
            m_rd_bank = 2'b11;
            m_wr_pend = 1'b0;
            m_rd_pend = 1'b0;
            prev_req  = 1'b0;
        end else begin
            if (wr_request || rd_request) begin
                g = model_grant();
                check("req_exclusive", 32'(wr_request && rd_request), 0);
                check("req_single_cycle", 32'(prev_req), 0);
                check("grant_kind", wr_request ? WR_K : RD_K, g);
                check("frame_pulse_before_next_req", {m_wr_pend, m_rd_pend}, 0);
                grant_log.push_back(wr_request ? WR_K : RD_K);
                m_last = wr_request ? WR_K : RD_K;
                if (wr_request) begin
                    wr_cnt++;
                    check("wr_addr_at_issue", wr_addr, exp_wr_addr());
                    if (!inflight_noresp) begin
                        m_wr_done++;
                        if (m_wr_done % BLK == 0) m_wr_pend = 1'b1;
                    end
                end else begin
                    rd_cnt++;
                    check("rd_addr_at_issue", rd_addr, exp_rd_addr());
                    if (!inflight_noresp) begin
                        m_rd_done++;
                        if (m_rd_done % BLK == 0) begin
                            m_rd_pend = 1'b1;
                            if (m_rd_bank == cur_wr_bank()) m_rd_bank = ~m_rd_bank;
                        end
                    end
                end
            end
            if (frame_wr_done) begin
                wr_frames++;
                check("frame_wr_done_expected", 32'(m_wr_pend), 1);
                m_wr_pend = 1'b0;
            end
            if (frame_rd_done) begin
                rd_frames++;
                check("frame_rd_done_expected", 32'(m_rd_pend), 1);
                m_rd_pend = 1'b0;
            end
            prev_req = wr_request || rd_request;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_reqs(input int kind, input int target, input string name);
        int n;
        int cur;
        n   = 0;
        cur = (kind == WR_K) ? wr_cnt : (kind == RD_K) ? rd_cnt : grant_log.size();
        while (cur < target && n < 400) begin
            step();
            n++;
            cur = (kind == WR_K) ? wr_cnt : (kind == RD_K) ? rd_cnt : grant_log.size();
        end
        check(name, 32'(cur >= target), 1);
    endtask

    task automatic quiesce_reset();
        init_done = 1'b0;
        wr_level  = '0;
        rd_level  = 9'd400;
        step(30);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int w0;
        int r0;
        int f0;
        int n;

        rst_n     = 1'b0;
        init_done = 1'b0;
        wr_level  = 9'd300;
        rd_level  = 9'd400;
        step(3);
        rst_n = 1'b1;

        // 1: reset state, no grant without init_done
        step(5);
        check("t1_wr_req_count", wr_cnt, 0);
        check("t1_rd_req_count", rd_cnt, 0);
        check("t1_wr_addr", wr_addr, 24'h000000);
        check("t1_rd_addr", rd_addr, 24'hC00000);
        check("t1_flags", {wr_request, rd_request, frame_wr_done, frame_rd_done, timeout_err}, 0);

        // 2: single write burst; address moves only after busy falls
        init_done = 1'b1;
        wait_reqs(WR_K, 1, "t2_wr_granted");
        wr_level = '0;
        step(3);
        check("t2_addr_held_during_busy", wr_addr, 24'h000000);
        step(20);
        check("t2_wr_addr_advanced", wr_addr, 24'h000100);
        check("t2_wr_req_count", wr_cnt, 1);
        check("t2_rd_req_count", rd_cnt, 0);
        check("t2_rd_addr", rd_addr, 24'hC00000);

        // 3: round-robin, then urgent read priority
        base     = grant_log.size();
        wr_level = 9'd300;
        rd_level = 9'd200;
        wait_reqs(NO_K, base + 4, "t3_four_grants");
        rd_level = 9'd10;
        check("t3_grant0_rd", grant_log[base + 0], RD_K);
        check("t3_grant1_wr", grant_log[base + 1], WR_K);
        check("t3_grant2_rd", grant_log[base + 2], RD_K);
        check("t3_grant3_wr", grant_log[base + 3], WR_K);
        wait_reqs(NO_K, base + 6, "t3_urgent_grants");
        init_done = 1'b0;
        wr_level  = '0;
        rd_level  = 9'd400;
        check("t3_grant4_urgent_rd", grant_log[base + 4], RD_K);
        check("t3_grant5_urgent_rd", grant_log[base + 5], RD_K);

        // 4: frame boundaries and bank ping-pong
        quiesce_reset();
        w0 = wr_cnt;
        f0 = wr_frames;
        init_done = 1'b1;
        wr_level  = 9'd300;
        wait_reqs(WR_K, w0 + 4, "t4_four_writes");
        wr_level = '0;
        step(20);
        check("t4_frame_wr_pulses", wr_frames - f0, 1);
        check("t4_wr_addr_bank_flip", wr_addr, 24'hC00000);

        r0 = rd_cnt;
        f0 = rd_frames;
        rd_level = 9'd100;
        wait_reqs(RD_K, r0 + 4, "t4_four_reads");
        rd_level = 9'd400;
        step(20);
        check("t4_frame_rd_pulses", rd_frames - f0, 1);
        check("t4_rd_bank_toggled", rd_addr, 24'h000000);

        rd_level = 9'd100;
        wait_reqs(RD_K, r0 + 8, "t4_repeat_reads");
        rd_level = 9'd400;
        step(20);
        check("t4_frame_rd_pulses_2", rd_frames - f0, 2);
        check("t4_rd_bank_held", rd_addr, 24'h000000);

        // 5: busy never rises -> sticky timeout, burst retried at same address
        quiesce_reset();
        w0 = wr_cnt;
        no_rise_next = 1'b1;
        init_done    = 1'b1;
        wr_level     = 9'd300;
        n = 0;
        while (!wr_request && n < 50) begin
            step();
            n++;
        end
        check("t5_request_seen", 32'(wr_request), 1);
        no_rise_next = 1'b0;
        step(64);
        check("t5_no_timeout_yet", 32'(timeout_err), 0);
        step(1);
        check("t5_timeout_set", 32'(timeout_err), 1);
        check("t5_addr_unchanged", wr_addr, 24'h000000);
        wait_reqs(WR_K, w0 + 2, "t5_retry_granted");
        wr_level = '0;
        step(20);
        check("t5_retry_advanced", wr_addr, 24'h000100);
        check("t5_timeout_sticky", 32'(timeout_err), 1);

        // 6: reset in the middle of a write burst
        quiesce_reset();
        w0 = wr_cnt;
        f0 = wr_frames;
        init_done = 1'b1;
        wr_level  = 9'd300;
        wait_reqs(WR_K, w0 + 2, "t6_second_write");
        step(4);
        rst_n     = 1'b0;
        init_done = 1'b0;
        wr_level  = '0;
        step(1);
        check("t6_reset_wr_addr", wr_addr, 24'h000000);
        check("t6_reset_rd_addr", rd_addr, 24'hC00000);
        check("t6_reset_flags", {wr_request, rd_request, frame_wr_done, frame_rd_done, timeout_err}, 0);
        rst_n = 1'b1;
        step(20);
        check("t6_addr_not_advanced", wr_addr, 24'h000000);
        check("t6_no_frame_pulse", wr_frames - f0, 0);
        check("t6_no_new_request", wr_cnt - w0, 2);

        step(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
